// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch mode controller.
// Contents: display geometry, adjust clamp limits, FSM state encoding,
// adjust-load payload struct and the per-digit clamp helper.
package stopwatch_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned NUM_W  = 4;

    localparam logic [NUM_W-1:0] MAX_TENS = NUM_W'(5);
    localparam logic [NUM_W-1:0] MAX_ONES = NUM_W'(9);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ADJ   = 2'd3
    } state_e;

    typedef struct packed {
        logic [SEL_W-1:0] digit;
        logic [NUM_W-1:0] val;
    } load_t;

    // Seconds-tens digit tops out at 5; every other digit at 9.
    function automatic logic [NUM_W-1:0] clamp_digit(input logic [SEL_W-1:0] sel,
                                                     input logic [NUM_W-1:0] num);
        logic [NUM_W-1:0] lim;
        lim = (sel == SEL_W'(1)) ? MAX_TENS : MAX_ONES;
        return (num > lim) ? lim : num;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle between the stopwatch mode controller and its surroundings.
// Inputs to the controller: tick_1hz, tick_adj, tick_blink, btn_clr,
// btn_pause, sw_adj, sw_sel, sw_num.
// Outputs from the controller: count_en, clr, load_en, load_digit,
// load_val, blank_mask, mode.
// slave = controller side, master = driver/observer side.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic              tick_1hz;
    logic              tick_adj;
    logic              tick_blink;
    logic              btn_clr;
    logic              btn_pause;
    logic              sw_adj;
    logic [SEL_W-1:0]  sw_sel;
    logic [NUM_W-1:0]  sw_num;

    logic              count_en;
    logic              clr;
    logic              load_en;
    logic [SEL_W-1:0]  load_digit;
    logic [NUM_W-1:0]  load_val;
    logic [DIGITS-1:0] blank_mask;
    logic [1:0]        mode;

    modport slave (
        input  tick_1hz, tick_adj, tick_blink, btn_clr, btn_pause,
               sw_adj, sw_sel, sw_num,
        output count_en, clr, load_en, load_digit, load_val,
               blank_mask, mode
    );

    modport master (
        output tick_1hz, tick_adj, tick_blink, btn_clr, btn_pause,
               sw_adj, sw_sel, sw_num,
        input  count_en, clr, load_en, load_digit, load_val,
               blank_mask, mode
    );

endinterface

// File: rtl/stopwatch_ctrl_edge_rise.sv
// Rising-edge detector for a debounced button level.
// Ports: clk, rst_n (async active-low), lvl (button level),
// pulse (combinational, high in the first cycle lvl reads 1).
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl,
    output logic pulse
);

    logic lvl_q;

    // Level history, sampled every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b0;
        else        lvl_q <= lvl;
    end

    assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Mode controller for the 4-digit MM:SS stopwatch.
// Ports: clk, rst_n (async active-low), bus (stopwatch_ctrl_if.slave).
// Turns button levels into events, sequences IDLE/RUN/PAUSE/ADJ, gates the
// 1 Hz tick into count_en, issues clear and clamped digit-load strobes and
// drives the blink mask for the digit under adjustment.
// count_en and blank_mask are combinational; all other outputs are flops.
module stopwatch_ctrl
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    stopwatch_ctrl_if.slave    bus
);

    logic   clr_ev;
    logic   pause_ev;
    state_e state_q, state_d;
    logic   por_q;
    logic   clr_q, clr_d;
    logic   load_en_q, load_en_d;
    load_t  load_q, load_d;
    logic   phase_q, phase_d;
    logic   adj_tick;

    edge_rise u_clr_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (bus.btn_clr),
        .pulse (clr_ev)
    );

    edge_rise u_pause_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (bus.btn_pause),
        .pulse (pause_ev)
    );

    // State and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            por_q     <= 1'b1;
            clr_q     <= 1'b0;
            load_en_q <= 1'b0;
            load_q    <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            por_q     <= 1'b0;
            clr_q     <= clr_d;
            load_en_q <= load_en_d;
            load_q    <= load_d;
            phase_q   <= phase_d;
        end
    end

    // Next state and next register values; sw_adj > clr_ev > pause_ev.
    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        load_en_d = 1'b0;
        load_d    = load_q;
        phase_d   = phase_q;
        adj_tick  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.sw_adj)    state_d = ST_ADJ;
                else if (clr_ev)   state_d = ST_IDLE;
                else if (pause_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.sw_adj)    state_d = ST_ADJ;
                else if (clr_ev)   state_d = ST_IDLE;
                else if (pause_ev) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (bus.sw_adj)    state_d = ST_ADJ;
                else if (clr_ev)   state_d = ST_IDLE;
                else if (pause_ev) state_d = ST_RUN;
            end
            ST_ADJ: begin
                if (!bus.sw_adj)   state_d = ST_PAUSE;
            end
            default: state_d = ST_IDLE;
        endcase

        // First clock after reset also clears the counter to 00:00.
        clr_d = clr_ev | por_q;

        // A clear in the same cycle as a load tick wins over the load.
        adj_tick  = bus.tick_adj & (state_q == ST_ADJ);
        load_en_d = adj_tick & ~clr_d;
        if (adj_tick) begin
            load_d.digit = bus.sw_sel;
            load_d.val   = clamp_digit(bus.sw_sel, bus.sw_num);
        end

        // Phase is held at 0 outside ADJ so every entry starts unblanked.
        if (state_q != ST_ADJ)   phase_d = 1'b0;
        else if (bus.tick_blink) phase_d = ~phase_q;
    end

    // Suppress the tick on the cycle RUN is being left.
    assign bus.count_en   = bus.tick_1hz & (state_q == ST_RUN) & (state_d == ST_RUN);
    assign bus.clr        = clr_q;
    assign bus.load_en    = load_en_q;
    assign bus.load_digit = load_q.digit;
    assign bus.load_val   = load_q.val;
    assign bus.blank_mask = (state_q == ST_ADJ && phase_q) ? (DIGITS'(1) << bus.sw_sel) : '0;
    assign bus.mode       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table, hold/reset sequences and
// random stimulus against a cycle-level behavioural model.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ADJ   = 3;

    typedef struct {
        logic       c, p, a;
        logic [1:0] sel;
        logic [3:0] num;
        logic       t1, ta, tb;
        logic [1:0] e_mode;
        logic       e_ce, e_clr, e_len;
        logic [1:0] e_ld;
        logic [3:0] e_lv;
        logic [3:0] e_blank;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int m_mode, m_ld, m_lv;
    bit m_pc, m_pp, m_first, m_clr, m_len, m_phase;

    vec_t tab[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int c, int p, int a, int sel, int num, int t1, int ta, int tb,
                                int em, int ece, int eclr, int elen, int eld, int elv, int eb);
        vec_t v;
        v.c = 1'(c); v.p = 1'(p); v.a = 1'(a); v.sel = 2'(sel); v.num = 4'(num);
        v.t1 = 1'(t1); v.ta = 1'(ta); v.tb = 1'(tb);
        v.e_mode = 2'(em); v.e_ce = 1'(ece); v.e_clr = 1'(eclr); v.e_len = 1'(elen);
        v.e_ld = 2'(eld); v.e_lv = 4'(elv); v.e_blank = 4'(eb);
        return v;
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_ld = 0; m_lv = 0;
        m_pc = 0; m_pp = 0; m_first = 1; m_clr = 0; m_len = 0; m_phase = 0;
    endfunction

    function automatic int model_next();
        bit ec, ep;
        ec = bus.btn_clr && !m_pc;
        ep = bus.btn_pause && !m_pp;
        if (m_mode == M_ADJ) return bus.sw_adj ? M_ADJ : M_PAUSE;
        if (bus.sw_adj) return M_ADJ;
        if (ec) return M_IDLE;
        if (ep) return (m_mode == M_RUN) ? M_PAUSE : M_RUN;
        return m_mode;
    endfunction

    task automatic model_check();
        int nx, eb;
        nx = model_next();
        eb = (m_mode == M_ADJ && m_phase) ? (1 << int'(bus.sw_sel)) : 0;
        chk("m_mode",   32'(bus.mode),       32'(m_mode));
        chk("m_cnt_en", 32'(bus.count_en),   32'(bus.tick_1hz && m_mode == M_RUN && nx == M_RUN));
        chk("m_clr",    32'(bus.clr),        32'(m_clr));
        chk("m_load",   32'(bus.load_en),    32'(m_len));
        chk("m_ldig",   32'(bus.load_digit), 32'(m_ld));
        chk("m_lval",   32'(bus.load_val),   32'(m_lv));
        chk("m_blank",  32'(bus.blank_mask), 32'(eb));
    endtask

    function automatic void model_advance();
        int nx, lim;
        bit adj;
        nx = model_next();
        m_clr = (bus.btn_clr && !m_pc) || m_first;
        adj = bus.tick_adj && m_mode == M_ADJ;
        m_len = adj && !m_clr;
        if (adj) begin
            m_ld = int'(bus.sw_sel);
            lim = (m_ld == 1) ? 5 : 9;
            m_lv = (int'(bus.sw_num) > lim) ? lim : int'(bus.sw_num);
        end
        m_phase = (m_mode == M_ADJ) ? (m_phase ^ bus.tick_blink) : 1'b0;
        m_first = 0;
        m_pc = bus.btn_clr;
        m_pp = bus.btn_pause;
        m_mode = nx;
    endfunction

    task automatic drive(input vec_t v);
        bus.btn_clr = v.c; bus.btn_pause = v.p; bus.sw_adj = v.a;
        bus.sw_sel = v.sel; bus.sw_num = v.num;
        bus.tick_1hz = v.t1; bus.tick_adj = v.ta; bus.tick_blink = v.tb;
    endtask

    // One clock: inputs applied just after posedge, outputs checked at negedge.
    task automatic step(input bit use_tab, input int idx, input vec_t v);
        drive(v);
        @(negedge clk);
        if (use_tab) begin
            chk($sformatf("r%0d_mode", idx),  32'(bus.mode),       32'(v.e_mode));
            chk($sformatf("r%0d_cnt", idx),   32'(bus.count_en),   32'(v.e_ce));
            chk($sformatf("r%0d_clr", idx),   32'(bus.clr),        32'(v.e_clr));
            chk($sformatf("r%0d_load", idx),  32'(bus.load_en),    32'(v.e_len));
            chk($sformatf("r%0d_ldig", idx),  32'(bus.load_digit), 32'(v.e_ld));
            chk($sformatf("r%0d_lval", idx),  32'(bus.load_val),   32'(v.e_lv));
            chk($sformatf("r%0d_blank", idx), 32'(bus.blank_mask), 32'(v.e_blank));
        end else begin
            model_check();
        end
        model_advance();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between clock edges and checks outputs drop immediately.
    task automatic async_reset_mid();
        #2;
        bus.tick_1hz = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ar_mode",  32'(bus.mode),       32'(M_IDLE));
        chk("ar_cnt",   32'(bus.count_en),   32'd0);
        chk("ar_clr",   32'(bus.clr),        32'd0);
        chk("ar_load",  32'(bus.load_en),    32'd0);
        chk("ar_lval",  32'(bus.load_val),   32'd0);
        chk("ar_blank", 32'(bus.blank_mask), 32'd0);
        drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        vec_t v;
        int trans, clr_cnt;
        logic [1:0] prev_mode;
        bit lc, lp, la;
        logic [1:0] ls;

        drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode",  32'(bus.mode),       32'd0);
        chk("rst_clr",   32'(bus.clr),        32'd0);
        chk("rst_load",  32'(bus.load_en),    32'd0);
        chk("rst_blank", 32'(bus.blank_mask), 32'd0);
        rst_n = 1'b1;

        //             c p a s  n t1 ta tb | mode ce clr len ld lv blank
        tab.push_back(mk(0,0,0,0, 0,0,0,0,   0,0,0,0,0,0,0));
        tab.push_back(mk(0,1,0,0, 0,0,0,0,   0,0,1,0,0,0,0));
        tab.push_back(mk(0,1,0,0, 0,1,0,0,   1,1,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0, 0,1,0,0,   1,1,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0, 0,1,0,0,   1,1,0,0,0,0,0));
        tab.push_back(mk(0,1,0,0, 0,1,0,0,   1,0,0,0,0,0,0));
        tab.push_back(mk(0,1,0,0, 0,1,0,0,   2,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0, 0,0,0,0,   2,0,0,0,0,0,0));
        tab.push_back(mk(0,1,0,0, 0,0,0,0,   2,0,0,0,0,0,0));
        tab.push_back(mk(0,0,0,0, 0,0,0,0,   1,0,0,0,0,0,0));
        tab.push_back(mk(1,1,0,0, 0,1,0,0,   1,0,0,0,0,0,0));
        tab.push_back(mk(1,1,0,0, 0,1,0,0,   0,0,1,0,0,0,0));
        tab.push_back(mk(0,0,0,0, 0,0,0,0,   0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,1,1,15,0,1,0,   0,0,0,0,0,0,0));
        tab.push_back(mk(0,0,1,1,15,0,1,0,   3,0,0,0,0,0,0));
        tab.push_back(mk(0,0,1,0,12,0,1,0,   3,0,0,1,1,5,0));
        tab.push_back(mk(0,0,1,2, 3,0,0,0,   3,0,0,1,0,9,0));
        tab.push_back(mk(0,0,1,2, 0,0,0,1,   3,0,0,0,0,9,0));
        tab.push_back(mk(0,0,1,2, 0,0,0,0,   3,0,0,0,0,9,4));
        tab.push_back(mk(0,0,1,2, 0,0,0,1,   3,0,0,0,0,9,4));
        tab.push_back(mk(0,0,1,2, 0,0,0,0,   3,0,0,0,0,9,0));
        tab.push_back(mk(0,0,1,2, 0,0,0,1,   3,0,0,0,0,9,0));
        tab.push_back(mk(0,0,1,2, 0,0,0,0,   3,0,0,0,0,9,4));
        tab.push_back(mk(1,0,1,2, 0,0,1,1,   3,0,0,0,0,9,4));
        tab.push_back(mk(0,0,1,2, 0,0,0,0,   3,0,1,0,2,0,0));
        tab.push_back(mk(0,0,0,2, 0,0,0,0,   3,0,0,0,2,0,0));
        tab.push_back(mk(0,0,0,2, 0,0,0,0,   2,0,0,0,2,0,0));

        for (int i = 0; i < tab.size(); i++) step(1'b1, i, tab[i]);

        // Long hold of start/pause yields one transition only.
        trans = 0;
        prev_mode = bus.mode;
        for (int i = 0; i < 1000; i++) begin
            step(1'b0, 0, mk(0,1,0,0,0,$urandom_range(0,1),0,0, 0,0,0,0,0,0,0));
            if (bus.mode !== prev_mode) trans++;
            prev_mode = bus.mode;
        end
        chk("hold_trans", 32'(trans), 32'd1);
        chk("hold_mode",  32'(bus.mode), 32'(M_RUN));
        for (int i = 0; i < 4; i++) step(1'b0, 0, mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++) step(1'b0, 0, mk(0,1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        chk("repress_mode", 32'(bus.mode), 32'(M_PAUSE));

        // Back to RUN, then reset between edges.
        step(1'b0, 0, mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        step(1'b0, 0, mk(0,1,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        step(1'b0, 0, mk(0,1,0,0,0,1,0,0, 0,0,0,0,0,0,0));
        chk("pre_ar_mode", 32'(bus.mode), 32'(M_RUN));
        async_reset_mid();
        clr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
            if (bus.clr === 1'b1) clr_cnt++;
        end
        chk("post_ar_clr_pulses", 32'(clr_cnt), 32'd1);

        // Random levels and ticks against the model.
        lc = 0; lp = 0; la = 0; ls = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0,7) == 0)  lc = ~lc;
            if ($urandom_range(0,5) == 0)  lp = ~lp;
            if ($urandom_range(0,39) == 0) la = ~la;
            if ($urandom_range(0,9) == 0)  ls = 2'($urandom_range(0,3));
            v = mk(int'(lc), int'(lp), int'(la), int'(ls), $urandom_range(0,15),
                   int'($urandom_range(0,3) == 0), int'($urandom_range(0,2) == 0),
                   int'($urandom_range(0,2) == 0), 0,0,0,0,0,0,0);
            if (i == 1500) async_reset_mid();
            step(1'b0, 0, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
